// File: rtl/scara_pkg.sv
// Shared types for the SCARA joint step generator.
//   angle_t      : signed joint angle / position in microsteps
//   steps_t      : unsigned remaining-step count
//   wide_t       : one bit wider than angle_t, holds any target-position difference
//   step_state_t : move sequencer states
package scara_pkg;

    localparam int unsigned ANGLE_W = 13;

    typedef logic signed [ANGLE_W-1:0] angle_t;
    typedef logic        [ANGLE_W-1:0] steps_t;
    typedef logic signed [ANGLE_W:0]   wide_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETUP,
        S_STEP,
        S_DONE
    } step_state_t;

    // Magnitude of a widened difference; any in-range delta fits ANGLE_W unsigned bits.
    function automatic steps_t abs_delta(input wide_t d);
        wide_t m;
        m = d[ANGLE_W] ? -d : d;
        return steps_t'(m);
    endfunction

endpackage

// File: rtl/joint_stepper.sv
// One stepper joint: remaining-step counter, absolute position, step/dir registers.
//   clk, reset  : clock, synchronous active-high reset
//   load        : capture direction and step count toward target
//   target      : destination angle, sampled on load
//   fire        : start of a step period; emits a step if steps remain
//   drop        : end of the step pulse
//   zero        : clear position (homing)
//   step, dir   : step pulse, direction (1 = decrementing)
//   pos         : absolute position in steps
//   rem_zero_c  : no steps remain in the current move
module joint_stepper
    import scara_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   load,
    input  angle_t target,
    input  logic   fire,
    input  logic   drop,
    input  logic   zero,
    output logic   step,
    output logic   dir,
    output angle_t pos,
    output logic   rem_zero_c
);

    steps_t rem;
    wide_t  delta_c;

    // Difference computed one bit wide so extreme targets cannot overflow.
    assign delta_c    = wide_t'(target) - wide_t'(pos);
    assign rem_zero_c = (rem == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            step <= 1'b0;
            dir  <= 1'b0;
            pos  <= '0;
            rem  <= '0;
        end else begin
            if (load) begin
                dir <= delta_c[ANGLE_W];
                rem <= abs_delta(delta_c);
            end else if (fire && (rem != '0)) begin
                step <= 1'b1;
                rem  <= rem - steps_t'(1);
                pos  <= dir ? (pos - angle_t'(1)) : (pos + angle_t'(1));
            end else if (drop) begin
                step <= 1'b0;
            end
            if (zero) begin
                pos <= '0;
            end
        end
    end

endmodule

// File: rtl/joint_step_generator.sv
// Two-joint step/dir generator driven by solved SCARA joint angles.
//   clk, reset         : clock, synchronous active-high reset
//   th1, th2           : target angles, latched on the rising edge of angles_ready
//   angles_ready       : solver data-ready level
//   home               : zero both positions (only while idle with nothing pending)
//   step1/2, dir1/2    : step pulses and directions (dir 1 = negative)
//   pos1/2             : absolute joint positions in steps
//   busy               : move in progress (target pickup until move_done)
//   move_done          : one-cycle pulse at move completion
module joint_step_generator
    import scara_pkg::*;
#(
    parameter int unsigned CLK_PER_STEP = 5000,
    parameter int unsigned PULSE_W      = 50,
    parameter int unsigned DIR_SETUP    = 10
) (
    input  logic   clk,
    input  logic   reset,
    input  angle_t th1,
    input  angle_t th2,
    input  logic   angles_ready,
    input  logic   home,
    output logic   step1,
    output logic   step2,
    output logic   dir1,
    output logic   dir2,
    output angle_t pos1,
    output angle_t pos2,
    output logic   busy,
    output logic   move_done
);

    localparam int unsigned CNT_MAX = (CLK_PER_STEP > DIR_SETUP) ? CLK_PER_STEP : DIR_SETUP;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef logic [CNT_W-1:0] cnt_t;

    step_state_t state;
    cnt_t        cnt;
    logic        ready_q;
    angle_t      pend1;
    angle_t      pend2;
    logic        pend_valid;

    logic        rise_c;
    logic        load_c;
    logic        fire_c;
    logic        drop_c;
    logic        zero_c;
    logic        rem_zero1_c;
    logic        rem_zero2_c;
    logic        no_move_c;

    assign rise_c    = angles_ready & ~ready_q;
    assign load_c    = (state == S_LOAD);
    assign fire_c    = (state == S_STEP) && (cnt == '0);
    assign drop_c    = (state == S_STEP) && (cnt == cnt_t'(PULSE_W));
    assign zero_c    = (state == S_IDLE) && !pend_valid && home;
    // Steppers load at the end of LOAD, so a null move is detected from the raw compare.
    assign no_move_c = (pend1 == pos1) && (pend2 == pos2);

    // Sequencer, pending-target buffer and ready edge detector.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            ready_q    <= 1'b0;
            pend1      <= '0;
            pend2      <= '0;
            pend_valid <= 1'b0;
            busy       <= 1'b0;
            move_done  <= 1'b0;
        end else begin
            ready_q   <= angles_ready;
            move_done <= 1'b0;

            // Newest target wins; an edge during LOAD keeps the buffer valid.
            if (rise_c) begin
                pend1      <= th1;
                pend2      <= th2;
                pend_valid <= 1'b1;
            end else if (state == S_LOAD) begin
                pend_valid <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (pend_valid) begin
                        state <= S_LOAD;
                        busy  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    cnt <= '0;
                    if (no_move_c) begin
                        state     <= S_DONE;
                        busy      <= 1'b0;
                        move_done <= 1'b1;
                    end else begin
                        state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (cnt == cnt_t'(DIR_SETUP - 1)) begin
                        state <= S_STEP;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + cnt_t'(1);
                    end
                end
                S_STEP: begin
                    if (cnt == cnt_t'(CLK_PER_STEP - 1)) begin
                        cnt <= '0;
                        if (rem_zero1_c && rem_zero2_c) begin
                            state     <= S_DONE;
                            busy      <= 1'b0;
                            move_done <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + cnt_t'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    joint_stepper u_joint1 (
        .clk        (clk),
        .reset      (reset),
        .load       (load_c),
        .target     (pend1),
        .fire       (fire_c),
        .drop       (drop_c),
        .zero       (zero_c),
        .step       (step1),
        .dir        (dir1),
        .pos        (pos1),
        .rem_zero_c (rem_zero1_c)
    );

    joint_stepper u_joint2 (
        .clk        (clk),
        .reset      (reset),
        .load       (load_c),
        .target     (pend2),
        .fire       (fire_c),
        .drop       (drop_c),
        .zero       (zero_c),
        .step       (step2),
        .dir        (dir2),
        .pos        (pos2),
        .rem_zero_c (rem_zero2_c)
    );

endmodule

// File: tb/tb_joint_step_generator.sv
// Scoreboard bench for joint_step_generator. Short step period keeps the full-range
// move (-4096 -> 4095) within a modest cycle count.
module tb_joint_step_generator;
    import scara_pkg::*;

    localparam int CPS   = 4;
    localparam int PW    = 2;
    localparam int SETUP = 3;

    logic   clk = 1'b0;
    logic   reset = 1'b1;
    angle_t th1 = '0;
    angle_t th2 = '0;
    logic   angles_ready = 1'b0;
    logic   home = 1'b0;
    logic   step1, step2, dir1, dir2, busy, move_done;
    angle_t pos1, pos2;

    joint_step_generator #(
        .CLK_PER_STEP (CPS),
        .PULSE_W      (PW),
        .DIR_SETUP    (SETUP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .th1          (th1),
        .th2          (th2),
        .angles_ready (angles_ready),
        .home         (home),
        .step1        (step1),
        .step2        (step2),
        .dir1         (dir1),
        .dir2         (dir2),
        .pos1         (pos1),
        .pos2         (pos2),
        .busy         (busy),
        .move_done    (move_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int p1; int p2;
        int s1; int s2;
        int d1; int d2;
        int blen;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   mp1 = 0;
    int   mp2 = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    // Reference model: steps, directions and busy time follow directly from the distance.
    task automatic expect_move(input int t1, input int t2);
        exp_t e;
        int   m;
        e.p1 = t1;  e.p2 = t2;
        e.s1 = iabs(t1 - mp1);
        e.s2 = iabs(t2 - mp2);
        e.d1 = (t1 < mp1) ? 1 : 0;
        e.d2 = (t2 < mp2) ? 1 : 0;
        m = (e.s1 > e.s2) ? e.s1 : e.s2;
        e.blen = 1 + ((m > 0) ? (SETUP + m * CPS) : 0);
        sb.push_back(e);
        mp1 = t1;
        mp2 = t2;
    endtask

    task automatic issue(input int t1, input int t2);
        th1 = angle_t'(t1);
        th2 = angle_t'(t2);
        angles_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 angles_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic go(input int t1, input int t2);
        expect_move(t1, t2);
        issue(t1, t2);
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while ((sb.size() != 0 || busy) && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("idle_within_budget", (k < budget) ? 1 : 0, 1);
        if (k >= budget) sb.delete();
    endtask

    // Monitor: pulse shape, latency and spacing per step; scoreboard pop on move_done.
    initial begin
        int   cyc, n1, n2, r1, r2, h1, h2, blen, lcyc;
        logic s1q, s2q, bq, mdq;
        exp_t e;
        cyc = 0; n1 = 0; n2 = 0; r1 = 0; r2 = 0; h1 = 0; h2 = 0; blen = 0; lcyc = 0;
        s1q = 1'b0; s2q = 1'b0; bq = 1'b0; mdq = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                sb.delete();
                n1 = 0; n2 = 0; h1 = 0; h2 = 0; blen = 0;
                s1q = 1'b0; s2q = 1'b0; bq = 1'b0; mdq = 1'b0;
            end else begin
                if (busy && !bq) lcyc = cyc;
                if (busy) blen++;

                if (step1 && !s1q) begin
                    if (sb.size() == 0) check("step1_unexpected", 1, 0);
                    else begin
                        if (n1 == 0) check("step1_latency", cyc - lcyc, 2 + SETUP);
                        else         check("step1_period", cyc - r1, CPS);
                        check("dir1_at_step", int'(dir1), sb[0].d1);
                    end
                    n1++; r1 = cyc; h1 = 1;
                end else if (step1) h1++;
                if (!step1 && s1q) check("step1_width", h1, PW);

                if (step2 && !s2q) begin
                    if (sb.size() == 0) check("step2_unexpected", 1, 0);
                    else begin
                        if (n2 == 0) check("step2_latency", cyc - lcyc, 2 + SETUP);
                        else         check("step2_period", cyc - r2, CPS);
                        check("dir2_at_step", int'(dir2), sb[0].d2);
                    end
                    n2++; r2 = cyc; h2 = 1;
                end else if (step2) h2++;
                if (!step2 && s2q) check("step2_width", h2, PW);

                if (move_done) begin
                    if (mdq) check("move_done_one_cycle", 1, 0);
                    if (sb.size() == 0) check("move_done_unexpected", 1, 0);
                    else begin
                        e = sb.pop_front();
                        check("pos1_final", int'(pos1), e.p1);
                        check("pos2_final", int'(pos2), e.p2);
                        check("step1_count", n1, e.s1);
                        check("step2_count", n2, e.s2);
                        check("busy_cycles", blen, e.blen);
                        check("busy_low_at_done", int'(busy), 0);
                    end
                    n1 = 0; n2 = 0; blen = 0;
                end

                s1q = step1; s2q = step2; bq = busy; mdq = move_done;
            end
        end
    end

    // Stimulus
    initial begin
        int t1, t2, rises;
        logic sq;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_step1", int'(step1), 0);
        check("rst_step2", int'(step2), 0);
        check("rst_dir1", int'(dir1), 0);
        check("rst_dir2", int'(dir2), 0);
        check("rst_pos1", int'(pos1), 0);
        check("rst_pos2", int'(pos2), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_move_done", int'(move_done), 0);

        // Basic move, then a null move to the same target
        go(5, -3);
        wait_idle(2000);
        go(5, -3);
        wait_idle(2000);

        // home ignored while busy
        go(30, 10);
        repeat (10) @(posedge clk);
        #1 home = 1'b1;
        @(posedge clk);
        #1 home = 1'b0;
        wait_idle(2000);

        // home while idle clears positions, no move
        home = 1'b1;
        @(posedge clk);
        #1 home = 1'b0;
        check("home_pos1", int'(pos1), 0);
        check("home_pos2", int'(pos2), 0);
        mp1 = 0; mp2 = 0;
        repeat (20) @(posedge clk);
        #1 check("home_no_busy", int'(busy), 0);

        // Two edges during a move: only the newest runs afterwards
        go(40, -20);
        repeat (30) @(posedge clk);
        #1 issue(10, 0);
        expect_move(20, 7);
        issue(20, 7);
        wait_idle(4000);

        // Randomized moves, some of them to the current position
        for (int i = 0; i < 8; i++) begin
            t1 = int'($urandom_range(120, 0)) - 60;
            t2 = int'($urandom_range(120, 0)) - 60;
            if (i % 4 == 3) begin t1 = mp1; t2 = mp2; end
            go(t1, t2);
            wait_idle(2000);
        end

        // Full-range move
        go(-4096, mp2);
        wait_idle(40000);
        go(4095, mp2);
        wait_idle(40000);

        // Reset while a step pulse is high
        go(100, -50);
        rises = 0;
        while (!step1 && rises < 200) begin
            @(posedge clk);
            #1;
            rises++;
        end
        check("step1_seen_before_abort", int'(step1), 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_step1", int'(step1), 0);
        check("abort_pos1", int'(pos1), 0);
        check("abort_pos2", int'(pos2), 0);
        check("abort_busy", int'(busy), 0);
        reset = 1'b0;
        mp1 = 0; mp2 = 0;
        rises = 0;
        sq = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if ((step1 || step2) && !sq) rises++;
            sq = step1 || step2;
        end
        check("abort_no_more_steps", rises, 0);
        check("scoreboard_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
